ssd_scan_driver: RTL

- Parametrised multiplexed seven-segment driver for the Nexys4 board's SSD bank; successor to the fixed 3-digit hex scan in the top level.
- Captures a binary value on a load strobe and optionally converts it to BCD with a sequential double-dabble engine.
- Applies leading-zero blanking, per-digit enable and decimal points, then time-multiplexes active-low anodes and cathodes.
- Sits between game logic (score/lives) and the board SSD pins.

---
 rtl/ssd_scan_driver_if.sv | 27 ++
 rtl/ssd_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver_if.sv
// Game-logic <-> seven-segment scan driver bundle: value/control in, status and board pins out.
// Latency and backpressure are properties of the driver; load is dropped while busy is high.
interface ssd_scan_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 16
);
    logic [BIN_WIDTH-1:0]  value;
    logic                  load;
    logic                  mode;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  busy;
    logic                  ovf;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            cathodes;

    modport master (
        output value, load, mode, blank_lz, dp_mask, digit_en,
        input  busy, ovf, an, cathodes
    );

    modport slave (
        input  value, load, mode, blank_lz, dp_mask, digit_en,
        output busy, ovf, an, cathodes
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed SSD driver: captures a value (hex or double-dabble BCD), blanks/dashes, scans active-low pins.
// Latency: pins lag idx by 1 cycle, BCD busy for BIN_WIDTH+1 cycles; no backpressure, load dropped while busy.
module ssd_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int BIN_WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ssd_scan_driver_if.slave bus
);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Decimal digit count of 2^BIN_WIDTH-1 is floor(BIN_WIDTH*log10(2))+1.
    localparam int BCD_DIGITS = (BIN_WIDTH * 30103) / 100000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int PAD_A      = (BIN_WIDTH > DISP_W) ? BIN_WIDTH : DISP_W;
    localparam int PAD_W      = (PAD_A > BCD_W) ? PAD_A : BCD_W;
    localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                   state, state_nxt;
    logic [SCAN_DIV_BITS-1:0] presc;
    logic [IDX_W-1:0]         idx;
    logic [BIN_WIDTH-1:0]     sh;
    logic [BCD_W-1:0]         bcd, bcd_adj;
    logic [CNT_W-1:0]         cnt;
    logic [DISP_W-1:0]        pending, display;
    logic                     pend_vld;
    logic                     ovf_q;
    logic [NUM_DIGITS-1:0]    an_q, an_nxt;
    logic [7:0]               cath_q, cath_nxt;
    logic [PAD_W-1:0]         val_pad, bcd_pad;
    logic                     hex_ovf, bcd_ovf;
    logic                     tick, frame;
    logic [NUM_DIGITS-1:0]    blank;
    logic                     zero_up;
    logic [3:0]               cur_digit;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: seg_of = 7'b0000001;
            4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;
            4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;
            4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;
            4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;
            4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;
            default: seg_of = 7'b0111000;
        endcase
    endfunction

    assign tick  = &presc;
    assign frame = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    assign val_pad = PAD_W'(bus.value);
    assign bcd_pad = PAD_W'(bcd);
    assign hex_ovf = |(val_pad >> DISP_W);
    assign bcd_ovf = |(bcd_pad >> DISP_W);

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load && bus.mode) state_nxt = CONV;
            CONV:    if (cnt == CNT_W'(BIN_WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // A new pending value written on the frame tick wins over the commit's clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            pending  <= '0;
            display  <= '0;
            pend_vld <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (frame && pend_vld) begin
                display  <= pending;
                pend_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.load && bus.mode) begin
                        sh  <= bus.value;
                        bcd <= '0;
                        cnt <= '0;
                    end else if (bus.load) begin
                        pending  <= val_pad[DISP_W-1:0];
                        ovf_q    <= hex_ovf;
                        pend_vld <= 1'b1;
                    end
                end
                CONV: begin
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    cnt       <= cnt + 1'b1;
                end
                DONE: begin
                    pending  <= bcd_pad[DISP_W-1:0];
                    ovf_q    <= bcd_ovf;
                    pend_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero run is scanned from the top digit down; overflow dashes override it.
    always_comb begin
        zero_up = 1'b1;
        blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_up  = zero_up && (display[4*i +: 4] == 4'h0);
            blank[i] = !bus.digit_en[i];
            if (i > 0 && bus.blank_lz && !ovf_q && zero_up) blank[i] = 1'b1;
        end
    end

    always_comb begin
        an_nxt    = '1;
        cath_nxt  = 8'hFF;
        cur_digit = display[4*idx +: 4];
        if (!blank[idx]) begin
            an_nxt[idx] = 1'b0;
            cath_nxt    = {(ovf_q ? SEG_DASH : seg_of(cur_digit)), ~bus.dp_mask[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '1;
            cath_q <= 8'hFF;
        end else begin
            an_q   <= an_nxt;
            cath_q <= cath_nxt;
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.ovf      = ovf_q;
    assign bus.an       = an_q;
    assign bus.cathodes = cath_q;
endmodule
